// File: rtl/alu_op_seq.sv
// Operand sequencer and result capture stage around an external combinational ALU.
// A request is accepted over valid/ready, and its operands are registered into the ALU.
// The ALU result and flags are captured on the following edge and are then held
// until the consumer takes them. The block also keeps the last result as an
// accumulator and a sticky overflow flag.
module alu_op_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [1:0]   op_ctrl,
  input  logic         op_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_ctrl,
  input  logic [W-1:0] alu_r,
  input  logic         alu_o,
  input  logic         alu_n,
  input  logic         alu_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_o,
  output logic         out_n,
  output logic         out_z,
  output logic [W-1:0] acc,
  output logic         ovf_sticky,
  input  logic         clr_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   alu_a_reg, alu_b_reg, out_r_reg, acc_reg;
  logic [1:0]     alu_ctrl_reg;
  logic           out_valid_reg, out_o_reg, out_n_reg, out_z_reg, ovf_sticky_reg;
  logic           accept;

  assign accept     = in_valid && in_ready;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_ctrl   = alu_ctrl_reg;
  assign out_valid  = out_valid_reg;
  assign out_r      = out_r_reg;
  assign out_o      = out_o_reg;
  assign out_n      = out_n_reg;
  assign out_z      = out_z_reg;
  assign acc        = acc_reg;
  assign ovf_sticky = ovf_sticky_reg;

  // Next-state and ready logic. In DONE the request side is only open when the
  // consumer is taking the current result on the same edge.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? EXEC : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand registers feeding the ALU. They change only on an accepted request.
  // A request accepted in DONE sees the accumulator already holding the result being handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_ctrl_reg <= 2'b00;
    end else if (accept) begin
      alu_a_reg    <= op_acc ? acc_reg : op_a;
      alu_b_reg    <= op_b;
      alu_ctrl_reg <= op_ctrl;
    end
  end

  // Capture the ALU result one cycle after acceptance and hold it until handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_reg <= '0;
      out_o_reg <= 1'b0;
      out_n_reg <= 1'b0;
      out_z_reg <= 1'b0;
      acc_reg   <= '0;
    end else if (state_reg == EXEC) begin
      out_r_reg <= alu_r;
      out_o_reg <= alu_o;
      out_n_reg <= alu_n;
      out_z_reg <= alu_z;
      acc_reg   <= alu_r;
    end
  end

  // Result valid flag. It is set by the capture and cleared only by the consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                out_valid_reg <= 1'b0;
    else if (state_reg == EXEC)                out_valid_reg <= 1'b1;
    else if (state_reg == DONE && out_ready)   out_valid_reg <= 1'b0;
  end

  // Sticky overflow. A captured overflow on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_sticky_reg <= 1'b0;
    else if (state_reg == EXEC)  ovf_sticky_reg <= (ovf_sticky_reg && !clr_ovf) || alu_o;
    else if (clr_ovf)            ovf_sticky_reg <= 1'b0;
  end

endmodule
